// File: rtl/chunked_adder.sv
// chunked_adder: multi-cycle WIDTH-bit adder/subtractor that sums CHUNK bits
// per clock, LSB chunk first, through one shared CHUNK-bit carry slice.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   operands/mode valid        in_ready   accepting (IDLE only)
//   a, b       WIDTH-bit operands
//   sub        0: a+b+cin, 1: a-b (cin ignored)
//   cin        carry-in for addition
//   out_valid  result/flags valid (DONE)  out_ready  consumer takes result
//   sum        result modulo 2^WIDTH
//   cout       carry out of MSB (subtraction: 1 = no borrow)
//   ovf        two's-complement signed overflow
//   zero       sum == 0
module chunked_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CW-1:0]    idx;
  logic             carry;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;

  int               base;
  logic [CHUNK-1:0] chunk_a;
  logic [CHUNK-1:0] chunk_b;
  logic [CHUNK-1:0] chunk_r;
  logic             chunk_c;
  logic             msb_cin;
  logic             last;
  logic [WIDTH-1:0] sum_next;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_comb begin
    base     = int'(idx) * CHUNK;
    chunk_a  = op_a[base +: CHUNK];
    chunk_b  = op_b[base +: CHUNK];
    {chunk_c, chunk_r} = {1'b0, chunk_a} + {1'b0, chunk_b} + {{CHUNK{1'b0}}, carry};
    // Carry into the top bit recovered from the slice's own MSB sum bit.
    msb_cin  = chunk_r[CHUNK-1] ^ chunk_a[CHUNK-1] ^ chunk_b[CHUNK-1];
    last     = (idx == CW'(N - 1));
    // Zero flag must see the chunk being written this cycle.
    sum_next = sum;
    sum_next[base +: CHUNK] = chunk_r;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      carry <= 1'b0;
      op_a  <= '0;
      op_b  <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_a  <= a;
            op_b  <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sum   <= sum_next;
          carry <= chunk_c;
          if (last) begin
            cout  <= chunk_c;
            ovf   <= msb_cin ^ chunk_c;
            zero  <= (sum_next == '0);
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chunked_adder.sv
module tb_chunked_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  // Main DUT: WIDTH=32, CHUNK=8 (N=4)
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        sub = 1'b0;
  logic        cin = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] sum;
  logic        cout, ovf, zero;

  // Shared stimulus for the parameter-sweep instances
  logic        s_valid = 1'b0;
  logic [31:0] s_a = '0;
  logic [31:0] s_b = '0;
  logic        s_sub = 1'b0;
  logic        s_cin = 1'b0;

  logic        r1_ir, r1_ov, r1_c, r1_o, r1_z;
  logic [31:0] r1_s;
  logic        r32_ir, r32_ov, r32_c, r32_o, r32_z;
  logic [31:0] r32_s;
  logic        r16_ir, r16_ov, r16_c, r16_o, r16_z;
  logic [15:0] r16_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  chunked_adder #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .cin(cin), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
  );

  chunked_adder #(.WIDTH(32), .CHUNK(32)) dut_n1 (
    .clk(clk), .rst_n(rst_n), .in_valid(s_valid), .in_ready(r1_ir),
    .a(s_a), .b(s_b), .sub(s_sub), .cin(s_cin), .out_valid(r1_ov),
    .out_ready(1'b1), .sum(r1_s), .cout(r1_c), .ovf(r1_o), .zero(r1_z)
  );

  chunked_adder #(.WIDTH(32), .CHUNK(1)) dut_n32 (
    .clk(clk), .rst_n(rst_n), .in_valid(s_valid), .in_ready(r32_ir),
    .a(s_a), .b(s_b), .sub(s_sub), .cin(s_cin), .out_valid(r32_ov),
    .out_ready(1'b1), .sum(r32_s), .cout(r32_c), .ovf(r32_o), .zero(r32_z)
  );

  chunked_adder #(.WIDTH(16), .CHUNK(4)) dut_w16 (
    .clk(clk), .rst_n(rst_n), .in_valid(s_valid), .in_ready(r16_ir),
    .a(s_a[15:0]), .b(s_b[15:0]), .sub(s_sub), .cin(s_cin), .out_valid(r16_ov),
    .out_ready(1'b1), .sum(r16_s), .cout(r16_c), .ovf(r16_o), .zero(r16_z)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [31:0] av, input logic [31:0] bv,
                          input logic sv, input logic cv);
    a = av; b = bv; sub = sv; cin = cv; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Cycles until out_valid is seen; 0 if the bound expires.
  task automatic wait_done(output int lat);
    lat = 0;
    for (int c = 1; c <= 64; c++) begin
      tick();
      if (out_valid) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  // Whole-word reference: returns {zero, ovf, cout, sum} for width w.
  function automatic logic [34:0] model(input int w, input logic [31:0] av,
                                        input logic [31:0] bv, input logic sv,
                                        input logic cv);
    logic [31:0] mask, aa, bb, r;
    logic [32:0] full;
    logic        c, o;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    aa   = av & mask;
    bb   = (sv ? ~bv : bv) & mask;
    full = {1'b0, aa} + {1'b0, bb} + {32'd0, (sv ? 1'b1 : cv)};
    r    = full[31:0] & mask;
    c    = full[w];
    o    = (aa[w-1] == bb[w-1]) && (r[w-1] != aa[w-1]);
    return {(r == 32'd0), o, c, r};
  endfunction

  initial begin
    int lat;
    int l1, l32, l16;
    logic [34:0] e1, e32, e16, g1, g32, g16;

    // Reset
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_flags", 64'({cout, ovf, zero}), 64'd0);
    rst_n = 1'b1;
    tick();

    // 1. Add with wrap
    start_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    chk("t1_busy", 64'(in_ready), 64'd0);
    wait_done(lat);
    chk("t1_lat", 64'(lat), 64'd4);
    chk("t1_sum", 64'(sum), 64'h0);
    chk("t1_flags", 64'({cout, ovf, zero}), 64'b101);
    consume();

    // 2. Signed overflow with cin, then plain add
    start_op(32'h7FFF_FFFF, 32'h0, 1'b0, 1'b1);
    wait_done(lat);
    chk("t2a_lat", 64'(lat), 64'd4);
    chk("t2a_sum", 64'(sum), 64'h8000_0000);
    chk("t2a_flags", 64'({cout, ovf, zero}), 64'b010);
    consume();
    start_op(32'h1234_5678, 32'h0F0F_0F0F, 1'b0, 1'b0);
    wait_done(lat);
    chk("t2b_sum", 64'(sum), 64'h2143_6587);
    chk("t2b_flags", 64'({cout, ovf, zero}), 64'b000);
    consume();

    // 3. Subtract
    start_op(32'd5, 32'd7, 1'b1, 1'b1);
    wait_done(lat);
    chk("t3a_sum", 64'(sum), 64'hFFFF_FFFE);
    chk("t3a_flags", 64'({cout, ovf, zero}), 64'b000);
    consume();
    start_op(32'h8000_0000, 32'd1, 1'b1, 1'b0);
    wait_done(lat);
    chk("t3b_sum", 64'(sum), 64'h7FFF_FFFF);
    chk("t3b_flags", 64'({cout, ovf, zero}), 64'b110);
    consume();

    // 4. Handshake: input disturbance during RUN, backpressure, back-to-back
    start_op(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0);
    tick();
    a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; sub = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_done(lat);
    chk("t4_lat_rest", 64'(lat), 64'd2);
    chk("t4_sum", 64'(sum), 64'h3333_3333);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t4_hold", 64'({out_valid, in_ready, sum, cout, ovf, zero}),
          64'({1'b1, 1'b0, 32'h3333_3333, 3'b000}));
    end
    a = 32'd1; b = 32'd2; sub = 1'b0; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t4_idle_after_consume", 64'({in_ready, out_valid}), 64'b10);
    tick();
    in_valid = 1'b0;
    chk("t4_b2b_accept", 64'(in_ready), 64'd0);
    wait_done(lat);
    chk("t4_b2b_lat", 64'(lat), 64'd4);
    chk("t4_b2b_sum", 64'(sum), 64'd3);
    consume();

    // 5. Reset mid-operation at idx=2
    start_op(32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 1'b0);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t5_rst_state", 64'({in_ready, out_valid}), 64'b10);
    chk("t5_rst_out", 64'({sum, cout, ovf, zero}), 64'd0);
    lat = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) lat++;
    end
    chk("t5_no_emit", 64'(lat), 64'd0);
    start_op(32'd3, 32'd4, 1'b0, 1'b0);
    wait_done(lat);
    chk("t5_lat", 64'(lat), 64'd4);
    chk("t5_sum", 64'(sum), 64'd7);
    chk("t5_flags", 64'({cout, ovf, zero}), 64'b000);
    consume();

    // 6. Parameter sweep against the whole-word model
    for (int t = 0; t < 8; t++) begin
      if (t == 0) begin
        s_a = 32'hFFFF_FFFF; s_b = 32'h0000_0001; s_sub = 1'b0; s_cin = 1'b0;
      end else if (t == 1) begin
        s_a = 32'h8000_8000; s_b = 32'h0000_0001; s_sub = 1'b1; s_cin = 1'b0;
      end else begin
        s_a = $urandom; s_b = $urandom;
        s_sub = 1'($urandom_range(0, 1)); s_cin = 1'($urandom_range(0, 1));
      end
      e1  = model(32, s_a, s_b, s_sub, s_cin);
      e32 = e1;
      e16 = model(16, s_a, s_b, s_sub, s_cin);
      chk("sw_ready", 64'({r1_ir, r32_ir, r16_ir}), 64'b111);
      s_valid = 1'b1;
      tick();
      s_valid = 1'b0;
      l1 = 0; l32 = 0; l16 = 0;
      g1 = '0; g32 = '0; g16 = '0;
      for (int c = 1; c <= 40; c++) begin
        tick();
        if (r1_ov && l1 == 0) begin
          l1 = c; g1 = {r1_z, r1_o, r1_c, r1_s};
        end
        if (r32_ov && l32 == 0) begin
          l32 = c; g32 = {r32_z, r32_o, r32_c, r32_s};
        end
        if (r16_ov && l16 == 0) begin
          l16 = c; g16 = {r16_z, r16_o, r16_c, 16'h0, r16_s};
        end
      end
      chk("sw_n1_lat", 64'(l1), 64'd1);
      chk("sw_n1_res", 64'(g1), 64'(e1));
      chk("sw_n32_lat", 64'(l32), 64'd32);
      chk("sw_n32_res", 64'(g32), 64'(e32));
      chk("sw_w16_lat", 64'(l16), 64'd4);
      chk("sw_w16_res", 64'(g16), 64'(e16));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
